// File: rtl/pattern_pkg.sv
// Shared types for the pattern sequencer.
// Entry record widths, FSM states, timeout default.
package pattern_pkg;

  localparam int DUTY_W = 8;
  localparam int GAP_W  = 16;
  localparam int PNUM_W = 8;
  localparam int LOOP_W = 8;
  localparam int ARM_TIMEOUT_DEF = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_DRAIN,
    S_NEXT
  } state_e;

  typedef struct packed {
    logic [DUTY_W-1:0] duty;
    logic [GAP_W-1:0]  gap;
    logic [PNUM_W-1:0] pnum;
    logic              last;
  } entry_t;

  function automatic logic [LOOP_W-1:0] sat_inc(
    input logic [LOOP_W-1:0] v
  );
    return (v == '1) ? v : v + LOOP_W'(1);
  endfunction

endpackage

// File: rtl/pattern_seq_ctrl_if.sv
// Burst table access bundle.
// master = sequencer side, slave = table side.
interface pattern_seq_ctrl_if #(
  parameter int AW = 2,
  parameter int PW = 8
);
  import pattern_pkg::*;

  logic          we;
  logic [AW-1:0] waddr;
  entry_t        wentry;
  logic [PW-1:0] wpat;
  logic [AW-1:0] raddr;
  entry_t        rentry;
  logic [PW-1:0] rpat;

  modport master (
    output we, waddr, wentry, wpat, raddr,
    input  rentry, rpat
  );

  modport slave (
    input  we, waddr, wentry, wpat, raddr,
    output rentry, rpat
  );

endinterface

// File: rtl/pattern_seq_table.sv
// Burst table: register array, one write port,
// one asynchronous read port.
module pattern_seq_table
  import pattern_pkg::*;
#(
  parameter int N_ENTRY   = 4,
  parameter int PAT_WIDTH = 8
) (
  input logic i_clk,
  input logic i_rst,
  pattern_seq_ctrl_if.slave tbl
);

  entry_t               r_ent [N_ENTRY];
  logic [PAT_WIDTH-1:0] r_pat [N_ENTRY];

  // write port; reset leaves a one-entry list
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < N_ENTRY; i++) begin
        r_ent[i] <= '0;
        r_pat[i] <= '0;
      end
      r_ent[0].last <= 1'b1;
    end else if (tbl.we) begin
      r_ent[tbl.waddr] <= tbl.wentry;
      r_pat[tbl.waddr] <= tbl.wpat;
    end
  end

  assign tbl.rentry = r_ent[tbl.raddr];
  assign tbl.rpat   = r_pat[tbl.raddr];

endmodule

// File: rtl/pattern_seq_ctrl.sv
// Pattern sequencer: walks the burst table and
// drives a pulse generator through each entry.
module pattern_seq_ctrl
  import pattern_pkg::*;
#(
  parameter int N_ENTRY     = 4,
  parameter int PAT_WIDTH   = 8,
  parameter int ARM_TIMEOUT = ARM_TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [$clog2(N_ENTRY)-1:0] cfg_addr,
  input  logic [7:0]                 cfg_duty,
  input  logic [15:0]                cfg_dessert,
  input  logic [7:0]                 cfg_pnum,
  input  logic [PAT_WIDTH-1:0]       cfg_pat,
  input  logic                       cfg_last,
  input  logic                       start,
  input  logic                       abort,
  input  logic [7:0]                 loop_num,
  output logic                       gen_en,
  output logic [7:0]                 gen_duty,
  output logic [15:0]                gen_dessert,
  output logic [7:0]                 gen_pnum,
  output logic [PAT_WIDTH-1:0]       gen_pat,
  input  logic                       gen_busy,
  output logic                       seq_busy,
  output logic                       seq_done,
  output logic                       seq_aborted,
  output logic                       seq_err,
  output logic [$clog2(N_ENTRY)-1:0] cur_entry,
  output logic [7:0]                 loop_cnt
);

  localparam int AW = $clog2(N_ENTRY);
  localparam int TW = $clog2(ARM_TIMEOUT + 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(N_ENTRY - 1);
  localparam logic [TW-1:0] TMO_END = TW'(ARM_TIMEOUT - 1);

  pattern_seq_ctrl_if #(.AW(AW), .PW(PAT_WIDTH)) u_tbl_if ();

  state_e               r_state, w_state;
  logic                 r_gen_en, w_gen_en;
  logic [DUTY_W-1:0]    r_duty;
  logic [GAP_W-1:0]     r_gap;
  logic [PNUM_W-1:0]    r_pnum;
  logic [PAT_WIDTH-1:0] r_pat;
  logic                 r_last;
  logic                 r_busy, w_busy;
  logic                 r_done, w_done;
  logic                 r_aborted, w_aborted;
  logic                 r_err, w_err;
  logic [AW-1:0]        r_entry, w_entry;
  logic [LOOP_W-1:0]    r_loop, w_loop;
  logic                 r_abort, w_abort;
  logic [TW-1:0]        r_tmo, w_tmo;
  logic                 w_load;
  logic [AW-1:0]        w_rd_addr;
  logic                 w_abt_any;
  logic [LOOP_W-1:0]    w_inc;

  // table is writable only while no sequence runs
  assign u_tbl_if.we     = cfg_we && (r_state == S_IDLE);
  assign u_tbl_if.waddr  = cfg_addr;
  assign u_tbl_if.wentry = '{duty: cfg_duty,
                             gap:  cfg_dessert,
                             pnum: cfg_pnum,
                             last: cfg_last};
  assign u_tbl_if.wpat   = cfg_pat;
  assign u_tbl_if.raddr  = w_rd_addr;

  pattern_seq_table #(
    .N_ENTRY  (N_ENTRY),
    .PAT_WIDTH(PAT_WIDTH)
  ) u_table (
    .i_clk(clk),
    .i_rst(rst),
    .tbl  (u_tbl_if)
  );

  // next state, pulses and table read address
  always_comb begin
    w_state   = r_state;
    w_busy    = r_busy;
    w_entry   = r_entry;
    w_loop    = r_loop;
    w_abort   = r_abort;
    w_tmo     = r_tmo;
    w_done    = 1'b0;
    w_aborted = 1'b0;
    w_err     = 1'b0;
    w_load    = 1'b0;
    w_rd_addr = '0;
    w_abt_any = r_abort | abort;
    w_inc     = sat_inc(r_loop);
    unique case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_state = S_ARM;
          w_busy  = 1'b1;
          w_entry = '0;
          w_loop  = '0;
          w_abort = 1'b0;
          w_load  = 1'b1;
        end
      end
      S_ARM: begin
        w_abort = w_abt_any;
        if (w_abt_any) begin
          w_state = S_DRAIN;
        end else if (gen_busy) begin
          w_state = S_RUN;
        end else if (r_tmo == TMO_END) begin
          w_state = S_IDLE;
          w_busy  = 1'b0;
          w_err   = 1'b1;
        end else begin
          w_tmo = r_tmo + TW'(1);
        end
      end
      S_RUN: begin
        w_abort = w_abt_any;
        if (r_pnum != '0 || w_abt_any) begin
          w_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_abort = w_abt_any;
        if (!gen_busy) begin
          if (w_abt_any) begin
            w_state   = S_IDLE;
            w_busy    = 1'b0;
            w_done    = 1'b1;
            w_aborted = 1'b1;
            w_abort   = 1'b0;
          end else begin
            w_state = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        if (!r_last && r_entry != LAST_IDX) begin
          w_entry   = r_entry + AW'(1);
          w_rd_addr = r_entry + AW'(1);
          w_state   = S_ARM;
          w_load    = 1'b1;
        end else begin
          w_loop = w_inc;
          if (loop_num != '0 && w_inc == loop_num) begin
            w_state = S_IDLE;
            w_busy  = 1'b0;
            w_done  = 1'b1;
          end else begin
            w_entry = '0;
            w_state = S_ARM;
            w_load  = 1'b1;
          end
        end
      end
      default: begin
        w_state = S_IDLE;
        w_busy  = 1'b0;
      end
    endcase
    if (r_state != S_ARM || w_state != S_ARM) begin
      w_tmo = '0;
    end
    w_gen_en = (w_state == S_ARM) ||
               (w_state == S_RUN && r_pnum == '0);
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_gen_en  <= 1'b0;
      r_duty    <= '0;
      r_gap     <= '0;
      r_pnum    <= '0;
      r_pat     <= '0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_err     <= 1'b0;
      r_entry   <= '0;
      r_loop    <= '0;
      r_abort   <= 1'b0;
      r_tmo     <= '0;
    end else begin
      r_state   <= w_state;
      r_gen_en  <= w_gen_en;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_aborted <= w_aborted;
      r_err     <= w_err;
      r_entry   <= w_entry;
      r_loop    <= w_loop;
      r_abort   <= w_abort;
      r_tmo     <= w_tmo;
      if (w_load) begin
        r_duty <= u_tbl_if.rentry.duty;
        r_gap  <= u_tbl_if.rentry.gap;
        r_pnum <= u_tbl_if.rentry.pnum;
        r_last <= u_tbl_if.rentry.last;
        r_pat  <= u_tbl_if.rpat;
      end
    end
  end

  assign gen_en      = r_gen_en;
  assign gen_duty    = r_duty;
  assign gen_dessert = r_gap;
  assign gen_pnum    = r_pnum;
  assign gen_pat     = r_pat;
  assign seq_busy    = r_busy;
  assign seq_done    = r_done;
  assign seq_aborted = r_aborted;
  assign seq_err     = r_err;
  assign cur_entry   = r_entry;
  assign loop_cnt    = r_loop;

endmodule

// File: tb/tb_pattern_seq_ctrl.sv
// Directed bench for pattern_seq_ctrl with a
// behavioural pulse generator model.
module tb_pattern_seq_ctrl;
  import pattern_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic start, abort;
  logic [7:0] loop_num;
  logic gen_en, gen_busy;
  logic [7:0] gen_duty, gen_pnum, gen_pat;
  logic [15:0] gen_dessert;
  logic seq_busy, seq_done, seq_aborted, seq_err;
  logic [1:0] cur_entry;
  logic [7:0] loop_cnt;

  pattern_seq_ctrl_if #(.AW(2), .PW(8)) cif ();

  int n_chk = 0;
  int n_err = 0;
  int c_done = 0, c_abt = 0, c_err = 0, c_tog = 0;
  logic g_ok;
  int g_cnt;
  logic [39:0] bq[$];

  typedef struct {
    int          n;
    logic [7:0]  lp;
    int          nb;
    logic [31:0] seq;
    logic [7:0]  lc;
    logic [1:0]  ce;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  assign cif.raddr  = '0;
  assign cif.rentry = '0;
  assign cif.rpat   = '0;

  pattern_seq_ctrl #(
    .N_ENTRY(4), .PAT_WIDTH(8), .ARM_TIMEOUT(15)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cif.we), .cfg_addr(cif.waddr),
    .cfg_duty(cif.wentry.duty),
    .cfg_dessert(cif.wentry.gap),
    .cfg_pnum(cif.wentry.pnum),
    .cfg_pat(cif.wpat),
    .cfg_last(cif.wentry.last),
    .start(start), .abort(abort),
    .loop_num(loop_num),
    .gen_en(gen_en), .gen_duty(gen_duty),
    .gen_dessert(gen_dessert),
    .gen_pnum(gen_pnum), .gen_pat(gen_pat),
    .gen_busy(gen_busy),
    .seq_busy(seq_busy), .seq_done(seq_done),
    .seq_aborted(seq_aborted), .seq_err(seq_err),
    .cur_entry(cur_entry), .loop_cnt(loop_cnt)
  );

  // generator: finite bursts last 3*pnum cycles,
  // endless ones stop 3 cycles after gen_en drops
  always @(posedge clk) begin
    if (rst || !g_ok) begin
      gen_busy <= 1'b0;
      g_cnt    <= 0;
    end else if (!gen_busy) begin
      if (gen_en) begin
        gen_busy <= 1'b1;
        g_cnt <= (gen_pnum == 0) ? 3 : 3 * int'(gen_pnum);
        bq.push_back({gen_duty, gen_dessert,
                      gen_pnum, gen_pat});
      end
    end else if (gen_pnum != 0 || !gen_en) begin
      if (g_cnt <= 1) gen_busy <= 1'b0;
      else g_cnt <= g_cnt - 1;
    end
  end

  // pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (seq_done) c_done++;
    if (seq_aborted) c_abt++;
    if (seq_err) c_err++;
    if (seq_done && seq_aborted) c_tog++;
  end

  task automatic chk(input string nm,
                     input logic [39:0] act,
                     input logic [39:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h",
               nm, act, exp);
    end
  endtask

  task automatic wr(input int a, input logic [7:0] d,
                    input logic [15:0] g,
                    input logic [7:0] p,
                    input logic [7:0] pt, input logic l);
    cif.we = 1'b1;
    cif.waddr = 2'(a);
    cif.wentry.duty = d;
    cif.wentry.gap = g;
    cif.wentry.pnum = p;
    cif.wentry.last = l;
    cif.wpat = pt;
    @(negedge clk);
    cif.we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int k;
    for (k = 0; k < lim; k++) begin
      if (!seq_busy) break;
      @(negedge clk);
    end
    n_chk++;
    if (k == lim) begin
      n_err++;
      $display("FAIL idle_timeout got=busy want=idle");
    end
    @(negedge clk);
  endtask

  initial begin
    int d0;
    int a0;
    int k;
    vecs[0] = '{2, 8'd2, 4, 32'h11101110, 8'd2, 2'd1};
    vecs[1] = '{1, 8'd3, 3, 32'h00101010, 8'd3, 2'd0};
    vecs[2] = '{4, 8'd1, 4, 32'h13121110, 8'd1, 2'd3};
    vecs[3] = '{3, 8'd1, 3, 32'h00121110, 8'd1, 2'd2};
    vecs[4] = '{2, 8'd1, 2, 32'h00001110, 8'd1, 2'd1};
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    loop_num = 8'd0; g_ok = 1'b1;
    cif.we = 1'b0; cif.waddr = '0;
    cif.wentry = '0; cif.wpat = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_gen_en", gen_en, 0);
    chk("rst_busy", seq_busy, 0);
    chk("rst_done", seq_done, 0);
    chk("rst_entry", cur_entry, 0);
    chk("rst_loop", loop_cnt, 0);
    chk("rst_gen", {gen_duty, gen_dessert,
                    gen_pnum, gen_pat}, 0);

    // REQ-025 hand sequence
    wr(0, 8'd2, 16'd4, 8'd3, 8'h05, 1'b0);
    wr(1, 8'd0, 16'd0, 8'd1, 8'hFF, 1'b1);
    loop_num = 8'd2;
    bq.delete(); d0 = c_done;
    pulse_start();
    wait_idle(2000);
    chk("r25_nburst", bq.size(), 4);
    for (int i = 0; i < bq.size() && i < 4; i++) begin
      chk($sformatf("r25_burst%0d", i), bq[i],
          (i % 2 == 0) ? 40'h02_0004_03_05
                       : 40'h00_0000_01_FF);
    end
    chk("r25_done", c_done - d0, 1);
    chk("r25_loop", loop_cnt, 2);

    // table-driven list/loop vectors
    foreach (vecs[v]) begin
      for (int e = 0; e < 4; e++) begin
        wr(e, 8'(e + 1), 16'(10 + e), 8'(e + 1),
           8'(8'h10 + e),
           (e == vecs[v].n - 1) && (vecs[v].n < 4));
      end
      loop_num = vecs[v].lp;
      bq.delete(); d0 = c_done;
      pulse_start();
      wait_idle(3000);
      chk($sformatf("v%0d_nburst", v),
          bq.size(), vecs[v].nb);
      for (int i = 0; i < bq.size() && i < 4; i++) begin
        chk($sformatf("v%0d_pat%0d", v, i),
            bq[i][7:0], vecs[v].seq[i*8 +: 8]);
      end
      chk($sformatf("v%0d_done", v), c_done - d0, 1);
      chk($sformatf("v%0d_loop", v),
          loop_cnt, vecs[v].lc);
      chk($sformatf("v%0d_entry", v),
          cur_entry, vecs[v].ce);
      chk($sformatf("v%0d_busy", v), seq_busy, 0);
    end

    // REQ-026 endless burst aborted
    wr(0, 8'd1, 16'd1, 8'd0, 8'h3C, 1'b1);
    loop_num = 8'd1;
    d0 = c_done; a0 = c_abt; k = c_tog;
    pulse_start();
    repeat (200) @(negedge clk);
    chk("r26_en_before", gen_en, 1);
    chk("r26_busy_before", seq_busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("r26_en_drop", gen_en, 0);
    chk("r26_draining", {seq_busy, gen_busy}, 2'b11);
    chk("r26_no_done_yet", c_done - d0, 0);
    wait_idle(100);
    chk("r26_done", c_done - d0, 1);
    chk("r26_aborted", c_abt - a0, 1);
    chk("r26_together", c_tog - k, 1);
    chk("r26_gen_idle", gen_busy, 0);

    // REQ-027 arm timeout
    g_ok = 1'b0;
    d0 = c_done; a0 = c_err;
    pulse_start();
    repeat (14) @(negedge clk);
    chk("r27_err_early", seq_err, 0);
    chk("r27_busy_early", seq_busy, 1);
    @(negedge clk);
    chk("r27_err", seq_err, 1);
    chk("r27_busy", seq_busy, 0);
    chk("r27_en", gen_en, 0);
    repeat (3) @(negedge clk);
    chk("r27_err_cnt", c_err - a0, 1);
    chk("r27_no_done", c_done - d0, 0);
    g_ok = 1'b1;

    // REQ-028 write while busy ignored
    wr(0, 8'd1, 16'd1, 8'd2, 8'h11, 1'b0);
    wr(1, 8'd1, 16'd1, 8'd2, 8'h22, 1'b1);
    loop_num = 8'd2;
    bq.delete();
    pulse_start();
    repeat (4) @(negedge clk);
    wr(1, 8'd1, 16'd1, 8'd2, 8'h99, 1'b1);
    wait_idle(2000);
    chk("r28_nburst", bq.size(), 4);
    if (bq.size() == 4) begin
      chk("r28_pats", {bq[0][7:0], bq[1][7:0],
                       bq[2][7:0], bq[3][7:0]},
          32'h11221122);
    end
    wr(1, 8'd1, 16'd1, 8'd2, 8'h99, 1'b1);
    loop_num = 8'd1;
    bq.delete();
    pulse_start();
    wait_idle(2000);
    chk("r28_idle_wr", bq.size() == 2 ?
        {bq[0][7:0], bq[1][7:0]} : 16'h0, 16'h1199);

    // REQ-029 start with abort in IDLE
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("r29_busy", seq_busy, 0);
    chk("r29_en", gen_en, 0);
    repeat (3) @(negedge clk);
    chk("r29_busy_late", {seq_busy, gen_en}, 0);

    // REQ-030 reset during entry 1
    wr(0, 8'd3, 16'd3, 8'd2, 8'h0A, 1'b0);
    wr(1, 8'd5, 16'd5, 8'd8, 8'hB0, 1'b1);
    d0 = c_done;
    pulse_start();
    for (k = 0; k < 500; k++) begin
      if (cur_entry == 2'd1 && gen_busy) break;
      @(negedge clk);
    end
    chk("r30_reach_e1", k < 500, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("r30_outs", {gen_en, seq_busy, seq_done,
                     seq_aborted, seq_err}, 0);
    chk("r30_gen", {gen_duty, gen_dessert,
                    gen_pnum, gen_pat}, 0);
    chk("r30_cnt", {cur_entry, loop_cnt}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("r30_no_done", c_done - d0, 0);
    pulse_start();
    chk("r30_e0", {gen_en, cur_entry}, 3'b100);
    chk("r30_tbl", {gen_pnum, gen_pat}, 0);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_idle(100);
    chk("r30_end", c_done - d0, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
